// File: rtl/cpu_mem_bus_ctrl_if.sv
// CPU-side handshake bundle for cpu_mem_bus_ctrl: address, direction, request and completion.
interface cpu_mem_bus_ctrl_if;
    logic [15:0] address;
    logic        rw;
    logic        req;
    logic        ready;
    logic        bus_err;

    // CPU side: issues cycles and watches completion.
    modport master (
        output address,
        output rw,
        output req,
        input  ready,
        input  bus_err
    );

    // Controller side.
    modport slave (
        input  address,
        input  rw,
        input  req,
        output ready,
        output bus_err
    );
endinterface

// File: rtl/cpu_mem_bus_ctrl.sv
// Memory-side bus controller: services CPU read/write cycles on a shared 16-bit data bus,
// sequences a synchronous SRAM with programmable wait states, and only drives the data bus
// during read completion.
module cpu_mem_bus_ctrl #(
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned ADDR_W      = 12,
    parameter logic [15:0] ERR_DATA    = 16'hDEAD
) (
    input  logic                  clock,
    input  logic                  reset,
    cpu_mem_bus_ctrl_if.slave     bus,
    // Tristate data bus stays a module port so drivers resolve at the boundary.
    inout  wire  [15:0]           data,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata
);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } state_e;

    state_e      state_q;
    logic [3:0]  wait_cnt_q;
    logic        rw_q;
    logic [15:0] rdata_q;
    logic        drive_q;
    logic        in_range;

    // Upper address bits beyond the implemented range must all be zero.
    assign in_range = (bus.address >> ADDR_W) == 16'd0;

    // Block drives the bus only while completing a read; reset clears drive_q at once.
    assign data = drive_q ? rdata_q : 16'hzzzz;

    // Access sequencer with registered handshake, SRAM and bus-drive outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            wait_cnt_q  <= 4'd0;
            rw_q        <= 1'b0;
            rdata_q     <= 16'd0;
            drive_q     <= 1'b0;
            bus.ready   <= 1'b0;
            bus.bus_err <= 1'b0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= 16'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    bus.ready   <= 1'b0;
                    bus.bus_err <= 1'b0;
                    drive_q     <= 1'b0;
                    if (bus.req) begin
                        rw_q <= bus.rw;
                        if (in_range) begin
                            state_q    <= StAccess;
                            wait_cnt_q <= 4'(WAIT_STATES);
                            mem_en     <= 1'b1;
                            mem_we     <= ~bus.rw;
                            mem_addr   <= bus.address[ADDR_W-1:0];
                            if (!bus.rw) begin
                                mem_wdata <= data;
                            end
                        end else begin
                            // Out of range: complete next cycle, SRAM untouched.
                            state_q     <= StDone;
                            bus.ready   <= 1'b1;
                            bus.bus_err <= 1'b1;
                            drive_q     <= bus.rw;
                            rdata_q     <= ERR_DATA;
                        end
                    end
                end
                StAccess: begin
                    if (wait_cnt_q == 4'd0) begin
                        state_q   <= StDone;
                        mem_en    <= 1'b0;
                        mem_we    <= 1'b0;
                        bus.ready <= 1'b1;
                        drive_q   <= rw_q;
                        if (rw_q) begin
                            rdata_q <= mem_rdata;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                StDone: begin
                    // One-cycle completion, then a turnaround cycle in IDLE.
                    state_q     <= StIdle;
                    bus.ready   <= 1'b0;
                    bus.bus_err <= 1'b0;
                    drive_q     <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
